// File: rtl/mem_access_ctrl_if.sv
// Data-bus bundle between the MEM-stage access controller and the memory
// side: request/grant handshake, registered request fields, response.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  bus_req;
  logic                  bus_we;
  logic [ADDR_W-1:0]     bus_addr;
  logic [DATA_W-1:0]     bus_wdata;
  logic [DATA_W/8-1:0]   bus_be;
  logic                  bus_gnt;
  logic                  bus_rvalid;
  logic [DATA_W-1:0]     bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer for a req/gnt/rvalid data bus.
// Holds the MEM stage while an access is in flight, lets a flushed access
// drain once granted, and aborts a wait that exceeds TIMEOUT cycles.
//
//  state  | meaning
//  IDLE   | no access; accept a new MEM-stage request
//  REQ    | bus_req high, waiting for grant (can still be withdrawn)
//  WAIT   | granted, waiting for rvalid; counts cycles toward timeout
//  DONE   | result stable, stall released; MEM/WB captures this edge
module mem_access_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mem_req_i,
  input  logic                mem_we_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  input  logic [DATA_W/8-1:0] mem_be_i,
  input  logic                flush_i,
  mem_access_ctrl_if.master   bus,
  output logic                stall_mem_o,
  output logic [DATA_W-1:0]   mem_rdata_o,
  output logic                timeout_o
);
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t                state_q, state_d;
  logic                  kill_q, kill_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W/8-1:0]   be_q, be_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  timeout_q, timeout_d;
  logic                  bus_req_c;
  logic                  stall_c;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      kill_q    <= 1'b0;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      rdata_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      kill_q    <= kill_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      rdata_q   <= rdata_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state, capture and handshake/stall decode.
  always_comb begin
    state_d   = state_q;
    kill_d    = kill_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    rdata_d   = rdata_q;
    timeout_d = 1'b0;
    bus_req_c = 1'b0;
    stall_c   = 1'b0;
    // Saturating increment so the counter can never wrap.
    cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        if (mem_req_i && !flush_i) begin
          stall_c = 1'b1;
          we_d    = mem_we_i;
          addr_d  = mem_addr_i;
          wdata_d = mem_wdata_i;
          be_d    = mem_be_i;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        stall_c   = 1'b1;
        bus_req_c = 1'b1;
        // An ungranted request may be withdrawn, so flush beats grant.
        if (flush_i) begin
          state_d = S_IDLE;
        end else if (bus.bus_gnt) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        stall_c = 1'b1;
        if (bus.bus_rvalid) begin
          kill_d = 1'b0;
          if (kill_q || flush_i) begin
            state_d = S_IDLE;
          end else begin
            if (!we_q) rdata_d = bus.bus_rdata;
            state_d = S_DONE;
          end
        end else if (cnt_inc == CNT_MAX) begin
          rdata_d   = '0;
          timeout_d = 1'b1;
          kill_d    = 1'b0;
          state_d   = (kill_q || flush_i) ? S_IDLE : S_DONE;
        end else begin
          cnt_d = cnt_inc;
          // Granted access must drain; remember to discard its result.
          if (flush_i) kill_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.bus_req   = bus_req_c;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;
  assign bus.bus_be    = be_q;
  assign stall_mem_o   = stall_c;
  assign mem_rdata_o   = rdata_q;
  assign timeout_o     = timeout_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl, built with TIMEOUT=4.
module tb_mem_access_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req, mem_we, flush;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        stall, timeout;
  logic [31:0] rdata;
  int          errors = 0;
  int          checks = 0;

  mem_access_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
    .mem_wdata_i(mem_wdata), .mem_be_i(mem_be), .flush_i(flush),
    .bus(bus_if.master),
    .stall_mem_o(stall), .mem_rdata_o(rdata), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_req = 0; mem_we = 0; flush = 0;
    mem_addr = 0; mem_wdata = 0; mem_be = 0;
    bus_if.bus_gnt = 0; bus_if.bus_rvalid = 0; bus_if.bus_rdata = 0;
    step(); step();
    rst_n = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b exp 0", stall); end
    checks++; if (bus_if.bus_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b exp 0", bus_if.bus_req); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h exp 0", rdata); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b exp 0", timeout); end
    checks++; if (bus_if.bus_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h exp 0", bus_if.bus_addr); end
    checks++; if (bus_if.bus_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b exp 0", bus_if.bus_we); end
  endtask

  task automatic test_load();
    step();
    mem_req = 1; mem_we = 0; mem_addr = 32'h40; mem_be = 4'hF;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL load_c0_stall: got %b exp 1", stall); end
    checks++; if (bus_if.bus_req !== 1'b0) begin errors++; $display("FAIL load_c0_req: got %b exp 0", bus_if.bus_req); end
    step();
    bus_if.bus_gnt = 1;
    #1;
    checks++; if (bus_if.bus_req !== 1'b1) begin errors++; $display("FAIL load_c1_req: got %b exp 1", bus_if.bus_req); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL load_c1_stall: got %b exp 1", stall); end
    checks++; if (bus_if.bus_addr !== 32'h40) begin errors++; $display("FAIL load_c1_addr: got %h exp 40", bus_if.bus_addr); end
    step();
    bus_if.bus_gnt = 0; bus_if.bus_rvalid = 1; bus_if.bus_rdata = 32'h12345678;
    #1;
    checks++; if (bus_if.bus_req !== 1'b0) begin errors++; $display("FAIL load_c2_req: got %b exp 0", bus_if.bus_req); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL load_c2_stall: got %b exp 1", stall); end
    step();
    bus_if.bus_rvalid = 0; bus_if.bus_rdata = 0; mem_req = 0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL load_c3_stall: got %b exp 0", stall); end
    checks++; if (rdata !== 32'h12345678) begin errors++; $display("FAIL load_c3_rdata: got %h exp 12345678", rdata); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL load_c3_timeout: got %b exp 0", timeout); end
    step();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL load_c4_stall: got %b exp 0", stall); end
    checks++; if (rdata !== 32'h12345678) begin errors++; $display("FAIL load_c4_rdata: got %h exp 12345678", rdata); end
  endtask

  task automatic test_store();
    mem_req = 1; mem_we = 1; mem_addr = 32'h100; mem_wdata = 32'hCAFEF00D; mem_be = 4'b0011;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL store_c0_stall: got %b exp 1", stall); end
    for (int i = 0; i < 5; i++) begin
      step();
      // Scramble the stage inputs: the bus fields must come from the registers.
      mem_we = 0; mem_addr = 32'hDEAD0000 + i; mem_wdata = 32'h0; mem_be = 4'hF;
      bus_if.bus_gnt = (i == 4);
      #1;
      checks++; if (bus_if.bus_req !== 1'b1) begin errors++; $display("FAIL store_req_%0d: got %b exp 1", i, bus_if.bus_req); end
      checks++; if (bus_if.bus_addr !== 32'h100) begin errors++; $display("FAIL store_addr_%0d: got %h exp 100", i, bus_if.bus_addr); end
      checks++; if (bus_if.bus_wdata !== 32'hCAFEF00D) begin errors++; $display("FAIL store_wdata_%0d: got %h exp cafef00d", i, bus_if.bus_wdata); end
      checks++; if (bus_if.bus_be !== 4'b0011) begin errors++; $display("FAIL store_be_%0d: got %b exp 0011", i, bus_if.bus_be); end
      checks++; if (bus_if.bus_we !== 1'b1) begin errors++; $display("FAIL store_we_%0d: got %b exp 1", i, bus_if.bus_we); end
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL store_stall_%0d: got %b exp 1", i, stall); end
    end
    step();
    bus_if.bus_gnt = 0; bus_if.bus_rvalid = 1; bus_if.bus_rdata = 32'h00000055; mem_req = 0;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL store_ack_stall: got %b exp 1", stall); end
    checks++; if (bus_if.bus_req !== 1'b0) begin errors++; $display("FAIL store_ack_req: got %b exp 0", bus_if.bus_req); end
    step();
    bus_if.bus_rvalid = 0; bus_if.bus_rdata = 0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL store_done_stall: got %b exp 0", stall); end
    checks++; if (rdata !== 32'h12345678) begin errors++; $display("FAIL store_done_rdata: got %h exp 12345678", rdata); end
    step();
  endtask

  task automatic test_flush_req();
    mem_req = 1; mem_we = 0; mem_addr = 32'h200; mem_be = 4'hF;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL freq_c0_stall: got %b exp 1", stall); end
    step();
    flush = 1;
    #1;
    checks++; if (bus_if.bus_req !== 1'b1) begin errors++; $display("FAIL freq_c1_req: got %b exp 1", bus_if.bus_req); end
    step();
    flush = 0; mem_req = 0;
    #1;
    checks++; if (bus_if.bus_req !== 1'b0) begin errors++; $display("FAIL freq_c2_req: got %b exp 0", bus_if.bus_req); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL freq_c2_stall: got %b exp 0", stall); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL freq_c2_timeout: got %b exp 0", timeout); end
    step();
    checks++; if (rdata !== 32'h12345678) begin errors++; $display("FAIL freq_c3_rdata: got %h exp 12345678", rdata); end
  endtask

  task automatic test_flush_wait();
    mem_req = 1; mem_we = 0; mem_addr = 32'h300; mem_be = 4'hF;
    step();
    bus_if.bus_gnt = 1;
    step();
    bus_if.bus_gnt = 0; flush = 1; mem_req = 0;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL fwait_w0_stall: got %b exp 1", stall); end
    for (int i = 1; i < 4; i++) begin
      step();
      flush = 0;
      if (i == 3) begin bus_if.bus_rvalid = 1; bus_if.bus_rdata = 32'hAAAA5555; end
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL fwait_w%0d_stall: got %b exp 1", i, stall); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL fwait_w%0d_timeout: got %b exp 0", i, timeout); end
    end
    step();
    bus_if.bus_rvalid = 0; bus_if.bus_rdata = 0;
    // A fresh request is accepted at once only if the controller is back in IDLE.
    mem_req = 1; mem_addr = 32'h400;
    #1;
    checks++; if (rdata !== 32'h12345678) begin errors++; $display("FAIL fwait_rdata: got %h exp 12345678", rdata); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL fwait_idle_stall: got %b exp 1", stall); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL fwait_idle_timeout: got %b exp 0", timeout); end
    step();
    flush = 1;
    #1;
    checks++; if (bus_if.bus_addr !== 32'h400) begin errors++; $display("FAIL fwait_new_addr: got %h exp 400", bus_if.bus_addr); end
    step();
    flush = 0; mem_req = 0;
    #1;
  endtask

  task automatic test_timeout();
    mem_req = 1; mem_we = 0; mem_addr = 32'h500; mem_be = 4'hF;
    step();
    bus_if.bus_gnt = 1;
    step();
    bus_if.bus_gnt = 0; mem_req = 0;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL tmo_w%0d_stall: got %b exp 1", i, stall); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL tmo_w%0d_timeout: got %b exp 0", i, timeout); end
    end
    step();
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL tmo_done_timeout: got %b exp 1", timeout); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL tmo_done_rdata: got %h exp 0", rdata); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL tmo_done_stall: got %b exp 0", stall); end
    step();
    // Back in IDLE: a new request must raise stall right away.
    mem_req = 1; mem_addr = 32'h540;
    #1;
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL tmo_idle_timeout: got %b exp 0", timeout); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL tmo_idle_stall: got %b exp 1", stall); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL tmo_idle_rdata: got %h exp 0", rdata); end
    step();
    flush = 1;
    step();
    flush = 0; mem_req = 0;
    #1;
  endtask

  task automatic test_reset_wait();
    bus_if.bus_rvalid = 1; bus_if.bus_rdata = 32'hBEEF0001;
    mem_req = 1; mem_we = 0; mem_addr = 32'h600; mem_be = 4'hF;
    step();
    bus_if.bus_rvalid = 0; bus_if.bus_gnt = 1;
    step();
    bus_if.bus_gnt = 0; bus_if.bus_rvalid = 1;
    step();
    bus_if.bus_rvalid = 0; mem_req = 0;
    step();
    checks++; if (rdata !== 32'hBEEF0001) begin errors++; $display("FAIL rstw_pre_rdata: got %h exp beef0001", rdata); end
    mem_req = 1; mem_we = 1; mem_addr = 32'h680; mem_wdata = 32'h77; mem_be = 4'hF;
    step();
    bus_if.bus_gnt = 1;
    step();
    bus_if.bus_gnt = 0; rst_n = 0; mem_req = 0;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rstw_wait_stall: got %b exp 1", stall); end
    step();
    rst_n = 1;
    #1;
    checks++; if (bus_if.bus_req !== 1'b0) begin errors++; $display("FAIL rstw_req: got %b exp 0", bus_if.bus_req); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rstw_stall: got %b exp 0", stall); end
    checks++; if (bus_if.bus_addr !== 32'h0) begin errors++; $display("FAIL rstw_addr: got %h exp 0", bus_if.bus_addr); end
    checks++; if (bus_if.bus_we !== 1'b0) begin errors++; $display("FAIL rstw_we: got %b exp 0", bus_if.bus_we); end
    checks++; if (bus_if.bus_wdata !== 32'h0) begin errors++; $display("FAIL rstw_wdata: got %h exp 0", bus_if.bus_wdata); end
    checks++; if (bus_if.bus_be !== 4'h0) begin errors++; $display("FAIL rstw_be: got %h exp 0", bus_if.bus_be); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rstw_rdata: got %h exp 0", rdata); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rstw_timeout: got %b exp 0", timeout); end
    bus_if.bus_rvalid = 1; bus_if.bus_rdata = 32'h99;
    step();
    bus_if.bus_rvalid = 0; bus_if.bus_rdata = 0;
    #1;
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rstw_late_rdata: got %h exp 0", rdata); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rstw_late_stall: got %b exp 0", stall); end
    checks++; if (bus_if.bus_req !== 1'b0) begin errors++; $display("FAIL rstw_late_req: got %b exp 0", bus_if.bus_req); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_flush_req();
    test_flush_wait();
    test_timeout();
    test_reset_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
